// File: rtl/ram_512x8_if.sv
// Request/response bundle between the control unit (master) and the
// 512x8 unified memory (slave): MOV/MOC four-phase handshake plus access fields.
interface ram_512x8_if;
    logic [31:0] DataOut;
    logic        MOC;
    logic        DMOC;
    logic        RW;
    logic        MOV;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [5:0]  OpC;

    modport master (
        input  DataOut, MOC, DMOC,
        output RW, MOV, Address, DataIn, OpC
    );

    modport slave (
        output DataOut, MOC, DMOC,
        input  RW, MOV, Address, DataIn, OpC
    );
endinterface

// File: rtl/ram_512x8.sv
// Big-endian 512x8 unified instruction/data memory with a MOV/MOC handshake.
// Define RAM_UNALIGNED_EN to drop alignment masking (addresses wrap mod 512).
module ram_512x8 (
    input  logic        clk,
    input  logic        reset,
    ram_512x8_if.slave  bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {S_IDLE, S_DONE} state_t;

    logic [7:0]  Mem [0:511];

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_moc;
    logic        r_dmoc;
    logic [31:0] r_dout;
    logic        w_moc_nxt;
    logic        w_dmoc_nxt;
    logic        w_access;
    logic        w_wr_en;
    logic        w_is_ldst;
    logic [1:0]  w_size;
    logic [8:0]  w_base;
    logic [8:0]  w_a0, w_a1, w_a2, w_a3;
    logic [31:0] w_rbytes;
    logic [31:0] w_rdata;

    // Access size depends on direction: a store opcode seen on a read is a full word.
    always_comb begin
        w_size = SZ_WORD;
        if (bus.RW) begin
            case (bus.OpC)
                OP_LB, OP_LBU: w_size = SZ_BYTE;
                OP_LH, OP_LHU: w_size = SZ_HALF;
                default:       w_size = SZ_WORD;
            endcase
        end else begin
            case (bus.OpC)
                OP_SB:   w_size = SZ_BYTE;
                OP_SH:   w_size = SZ_HALF;
                default: w_size = SZ_WORD;
            endcase
        end
    end

    always_comb begin
        case (bus.OpC)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: w_is_ldst = 1'b1;
            default:             w_is_ldst = 1'b0;
        endcase
    end

`ifdef RAM_UNALIGNED_EN
    always_comb begin
        w_base = bus.Address;
    end
`else
    // Alignment masking keeps every access inside one aligned word, never past 511.
    always_comb begin
        case (w_size)
            SZ_WORD: w_base = {bus.Address[8:2], 2'b00};
            SZ_HALF: w_base = {bus.Address[8:1], 1'b0};
            default: w_base = bus.Address;
        endcase
    end
`endif

    // 9-bit adds wrap modulo 512 on their own.
    assign w_a0 = w_base;
    assign w_a1 = w_base + 9'd1;
    assign w_a2 = w_base + 9'd2;
    assign w_a3 = w_base + 9'd3;

    assign w_rbytes = {Mem[w_a0], Mem[w_a1], Mem[w_a2], Mem[w_a3]};

    always_comb begin
        case (bus.OpC)
            OP_LB:   w_rdata = {{24{w_rbytes[31]}}, w_rbytes[31:24]};
            OP_LBU:  w_rdata = {24'd0, w_rbytes[31:24]};
            OP_LH:   w_rdata = {{16{w_rbytes[31]}}, w_rbytes[31:16]};
            OP_LHU:  w_rdata = {16'd0, w_rbytes[31:16]};
            default: w_rdata = w_rbytes;
        endcase
    end

    // Handshake: one access on IDLE->DONE, then wait for MOV to drop.
    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        w_moc_nxt   = r_moc;
        w_dmoc_nxt  = r_dmoc;
        case (r_state)
            S_IDLE: begin
                if (bus.MOV) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_DONE;
                    w_moc_nxt   = 1'b1;
                    w_dmoc_nxt  = w_is_ldst;
                end
            end
            S_DONE: begin
                if (!bus.MOV) begin
                    w_state_nxt = S_IDLE;
                    w_moc_nxt   = 1'b0;
                    w_dmoc_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_moc   <= 1'b0;
            r_dmoc  <= 1'b0;
            r_dout  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_moc   <= w_moc_nxt;
            r_dmoc  <= w_dmoc_nxt;
            if (w_access && bus.RW)
                r_dout <= w_rdata;
        end
    end

    // Storage has no reset; the explicit reset term blocks writes while reset is held.
    assign w_wr_en = w_access & ~bus.RW & reset;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            case (w_size)
                SZ_BYTE: begin
                    Mem[w_a0] <= bus.DataIn[7:0];
                end
                SZ_HALF: begin
                    Mem[w_a0] <= bus.DataIn[15:8];
                    Mem[w_a1] <= bus.DataIn[7:0];
                end
                default: begin
                    Mem[w_a0] <= bus.DataIn[31:24];
                    Mem[w_a1] <= bus.DataIn[23:16];
                    Mem[w_a2] <= bus.DataIn[15:8];
                    Mem[w_a3] <= bus.DataIn[7:0];
                end
            endcase
        end
    end

    assign bus.DataOut = r_dout;
    assign bus.MOC     = r_moc;
    assign bus.DMOC    = r_dmoc;
endmodule

// File: tb/tb_ram_512x8.sv
// Directed bench for ram_512x8: handshake timing, load/store sizes, alignment, reset.
module tb_ram_512x8;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    ram_512x8_if bus ();

    ram_512x8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_req(input logic rw, input logic [8:0] addr,
                             input logic [5:0] opc, input logic [31:0] din);
        @(negedge clk);
        bus.RW      = rw;
        bus.Address = addr;
        bus.OpC     = opc;
        bus.DataIn  = din;
        bus.MOV     = 1'b1;
    endtask

    task automatic drop_req();
        @(negedge clk);
        bus.MOV = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.MOC !== 1'b0 || bus.DMOC !== 1'b0 || bus.DataOut !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got moc=%b dmoc=%b dout=%h want 0 0 00000000",
                     bus.MOC, bus.DMOC, bus.DataOut);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        drive_req(1'b1, 9'd0, 6'h00, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.DataOut !== 32'h8C010004 || bus.MOC !== 1'b1 || bus.DMOC !== 1'b0) begin
            bad++;
            $display("FAIL fetch: got dout=%h moc=%b dmoc=%b want 8c010004 1 0",
                     bus.DataOut, bus.MOC, bus.DMOC);
        end
        drop_req();
        @(posedge clk); #1;
        total++;
        if (bus.MOC !== 1'b0) begin
            bad++;
            $display("FAIL fetch_moc_drop: got moc=%b want 0", bus.MOC);
        end
    endtask

    task automatic test_byte_loads();
        drive_req(1'b1, 9'd8, 6'h20, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.DataOut !== 32'hFFFFFF80 || bus.DMOC !== 1'b1) begin
            bad++;
            $display("FAIL lb: got dout=%h dmoc=%b want ffffff80 1", bus.DataOut, bus.DMOC);
        end
        drop_req();
        @(posedge clk);
        drive_req(1'b1, 9'd8, 6'h24, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.DataOut !== 32'h00000080 || bus.DMOC !== 1'b1) begin
            bad++;
            $display("FAIL lbu: got dout=%h dmoc=%b want 00000080 1", bus.DataOut, bus.DMOC);
        end
        drop_req();
        @(posedge clk);
    endtask

    task automatic test_halfword();
        drive_req(1'b0, 9'd6, 6'h29, 32'h1234ABCD);
        @(posedge clk); #1;
        total++;
        if (dut.Mem[6] !== 8'hAB || dut.Mem[7] !== 8'hCD) begin
            bad++;
            $display("FAIL sh_bytes: got %h %h want ab cd", dut.Mem[6], dut.Mem[7]);
        end
        total++;
        if (dut.Mem[4] !== 8'h55 || dut.Mem[5] !== 8'h66) begin
            bad++;
            $display("FAIL sh_neighbours: got %h %h want 55 66", dut.Mem[4], dut.Mem[5]);
        end
        total++;
        if (bus.DataOut !== 32'h00000080) begin
            bad++;
            $display("FAIL store_keeps_dout: got %h want 00000080", bus.DataOut);
        end
        drop_req();
        @(posedge clk);
        drive_req(1'b1, 9'd6, 6'h25, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.DataOut !== 32'h0000ABCD) begin
            bad++;
            $display("FAIL lhu: got %h want 0000abcd", bus.DataOut);
        end
        drop_req();
        @(posedge clk);
        drive_req(1'b1, 9'd7, 6'h21, 32'd0);
        @(posedge clk); #1;
        total++;
`ifdef RAM_UNALIGNED_EN
        if (bus.DataOut !== 32'hFFFFCD80) begin
            bad++;
            $display("FAIL lh_odd: got %h want ffffcd80", bus.DataOut);
        end
`else
        if (bus.DataOut !== 32'hFFFFABCD) begin
            bad++;
            $display("FAIL lh_odd: got %h want ffffabcd", bus.DataOut);
        end
`endif
        drop_req();
        @(posedge clk);
    endtask

    task automatic test_word_align();
        drive_req(1'b0, 9'd13, 6'h2B, 32'hDEADBEEF);
        @(posedge clk); #1;
        total++;
`ifdef RAM_UNALIGNED_EN
        if (dut.Mem[13] !== 8'hDE || dut.Mem[16] !== 8'hEF || dut.Mem[12] !== 8'h99) begin
            bad++;
            $display("FAIL sw_13: got m12=%h m13=%h m16=%h want 99 de ef",
                     dut.Mem[12], dut.Mem[13], dut.Mem[16]);
        end
`else
        if (dut.Mem[12] !== 8'hDE || dut.Mem[15] !== 8'hEF || dut.Mem[16] !== 8'h77) begin
            bad++;
            $display("FAIL sw_13: got m12=%h m15=%h m16=%h want de ef 77",
                     dut.Mem[12], dut.Mem[15], dut.Mem[16]);
        end
`endif
        drop_req();
        @(posedge clk);
        drive_req(1'b1, 9'd510, 6'h23, 32'd0);
        @(posedge clk); #1;
        total++;
`ifdef RAM_UNALIGNED_EN
        if (bus.DataOut !== 32'h11228C01) begin
            bad++;
            $display("FAIL lw_510: got %h want 11228c01", bus.DataOut);
        end
`else
        if (bus.DataOut !== 32'hA1A21122) begin
            bad++;
            $display("FAIL lw_510: got %h want a1a21122", bus.DataOut);
        end
`endif
        drop_req();
        @(posedge clk);
    endtask

    task automatic test_hold();
        drive_req(1'b0, 9'd20, 6'h28, 32'h1234565A);
        @(posedge clk); #1;
        total++;
        if (dut.Mem[20] !== 8'h5A || bus.MOC !== 1'b1 || bus.DMOC !== 1'b1) begin
            bad++;
            $display("FAIL sb_first: got mem=%h moc=%b dmoc=%b want 5a 1 1",
                     dut.Mem[20], bus.MOC, bus.DMOC);
        end
        @(negedge clk);
        dut.Mem[20] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.MOC !== 1'b1) begin
                bad++;
                $display("FAIL hold_moc[%0d]: got %b want 1", i, bus.MOC);
            end
        end
        total++;
        if (dut.Mem[20] !== 8'h11) begin
            bad++;
            $display("FAIL hold_single_write: got %h want 11", dut.Mem[20]);
        end
        drop_req();
        @(posedge clk); #1;
        total++;
        if (bus.MOC !== 1'b0 || bus.DMOC !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: got moc=%b dmoc=%b want 0 0", bus.MOC, bus.DMOC);
        end
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, 9'd0, 6'h23, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.MOC !== 1'b1 || bus.DMOC !== 1'b1 || bus.DataOut !== 32'h8C010004) begin
            bad++;
            $display("FAIL lw_pre_reset: got moc=%b dmoc=%b dout=%h want 1 1 8c010004",
                     bus.MOC, bus.DMOC, bus.DataOut);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (bus.MOC !== 1'b0 || bus.DMOC !== 1'b0 || bus.DataOut !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: got moc=%b dmoc=%b dout=%h want 0 0 00000000",
                     bus.MOC, bus.DMOC, bus.DataOut);
        end
        bus.RW     = 1'b0;
        bus.OpC    = 6'h2B;
        bus.DataIn = 32'hFFFFFFFF;
        @(posedge clk); #1;
        total++;
        if ({dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]} !== 32'h8C010004) begin
            bad++;
            $display("FAIL no_write_in_reset: got %h%h%h%h want 8c010004",
                     dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]);
        end
        drop_req();
        reset = 1'b1;
        drive_req(1'b1, 9'd0, 6'h00, 32'd0);
        @(posedge clk); #1;
        total++;
        if (bus.DataOut !== 32'h8C010004 || bus.MOC !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_fetch: got dout=%h moc=%b want 8c010004 1",
                     bus.DataOut, bus.MOC);
        end
        drop_req();
        @(posedge clk);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        bus.MOV     = 1'b0;
        bus.RW      = 1'b1;
        bus.Address = 9'd0;
        bus.DataIn  = 32'd0;
        bus.OpC     = 6'h00;
        for (int i = 0; i < 512; i++) dut.Mem[i] = 8'h00;
        dut.Mem[0]   = 8'h8C;
        dut.Mem[1]   = 8'h01;
        dut.Mem[2]   = 8'h00;
        dut.Mem[3]   = 8'h04;
        dut.Mem[4]   = 8'h55;
        dut.Mem[5]   = 8'h66;
        dut.Mem[8]   = 8'h80;
        dut.Mem[12]  = 8'h99;
        dut.Mem[16]  = 8'h77;
        dut.Mem[508] = 8'hA1;
        dut.Mem[509] = 8'hA2;
        dut.Mem[510] = 8'h11;
        dut.Mem[511] = 8'h22;

        test_reset();
        test_fetch();
        test_byte_loads();
        test_halfword();
        test_word_align();
        test_hold();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_512x8.md
# ram_512x8

Byte-addressable 512 x 8 synchronous memory serving as the unified instruction/data store of the multi-cycle MIPS datapath. It answers MAR-addressed requests from the control unit with a four-phase MOV/MOC handshake. It supports MIPS byte, halfword and word loads (signed and unsigned) and byte, halfword and word stores, all big-endian. The storage array is named `Mem[0:511]` (8-bit entries) so benches can preload and dump it hierarchically.

## Interface
Parameters: none.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `DataOut` out 32: read data, sign/zero-extended per `OpC`.
- `MOC` out 1: memory operation complete.
- `DMOC` out 1: data-access complete; `MOC` qualified by a load/store opcode.
- `RW` in 1: 1 = read, 0 = write.
- `MOV` in 1: memory operation valid (request).
- `Address` in 9: byte address (MAR[8:0]).
- `DataIn` in 32: store data; the low byte/halfword is used for SB/SH.
- `OpC` in 6: instruction opcode that selects access size.

## Operation
- Big-endian: byte at A is the most significant byte. Word = {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}.
- Reads (RW=1):
  - 0x20 LB: sign-extend Mem[A].
  - 0x24 LBU: zero-extend Mem[A].
  - 0x21 LH: sign-extend {Mem[A],Mem[A+1]}.
  - 0x25 LHU: zero-extend {Mem[A],Mem[A+1]}.
  - 0x23 LW, or any other opcode (instruction fetch): full word.
- Writes (RW=0):
  - 0x28 SB: Mem[A] = DataIn[7:0].
  - 0x29 SH: 2 bytes from DataIn[15:0].
  - 0x2B SW, or any other opcode: 4 bytes from DataIn[31:0].
- Alignment (default build): word accesses clear A[1:0] and halfword accesses clear A[0], so no access crosses address 511.
- `DMOC` rises with `MOC` only when `OpC` is one of the eight load/store codes above; otherwise `DMOC` stays 0.
- Reset clears `DataOut`, `MOC` and `DMOC` to 0. `Mem` is never cleared by reset, so preloaded contents survive.

## Timing
- Handshake states are IDLE and DONE.
  - IDLE: on a rising edge with MOV=1, the access is performed at that edge. Write bytes update `Mem`, or `DataOut` is registered. `MOC` (and `DMOC` if applicable) goes to 1 at that edge, and the state becomes DONE.
  - DONE: `MOC` stays 1 while MOV=1. No further access is performed, so each MOV assertion performs exactly one access. The first edge with MOV=0 clears `MOC`/`DMOC` and returns to IDLE.
- Read latency: `DataOut` is valid on the same edge that `MOC` rises. `DataOut` holds its value until the next read.
- `Address`, `DataIn`, `RW` and `OpC` must be stable from MOV rising until MOC is seen high. They are sampled only on the IDLE→DONE edge.
- Back-to-back accesses: MOV must drop for at least one edge between accesses. Minimum period is 2 cycles per access.
- Reset asserted mid-operation forces IDLE immediately. A write already committed on an earlier edge remains in `Mem`. With reset low, no `Mem` write occurs.
- MOV=0 in IDLE: outputs hold and no access occurs.

## Configuration
- `RAM_UNALIGNED_EN`:
  - Defined: no alignment masking. Halfword/word accesses use bytes A..A+1 / A..A+3, with addresses wrapping modulo 512 (for example, a word at 510 is {Mem[510],Mem[511],Mem[0],Mem[1]}).
  - Undefined: the alignment masking rules in Operation apply.

## Test plan
- Preload Mem[0..3] = 8C,01,00,04; read with OpC=0x00, RW=1 → `DataOut` = 0x8C010004, `MOC`=1 one edge after MOV, `DMOC`=0.
- Mem[8] = 0x80: LB at 8 → 0xFFFFFF80; LBU → 0x00000080; `DMOC`=1 for both.
- SH at A=6 with DataIn = 0x1234ABCD → Mem[6]=AB, Mem[7]=CD, Mem[4..5] unchanged; then LHU at 6 → 0x0000ABCD.
- SW at A=13 (default build) → writes Mem[12..15]. With `RAM_UNALIGNED_EN`, LW at 510 wraps to Mem[0..1].
- Hold MOV=1 for 5 cycles with an SB → exactly one write. `MOC` stays 1 until MOV drops, then reaches 0 one edge later.
- Assert reset low while MOC=1 → `MOC`, `DMOC` and `DataOut` are 0 immediately and the preloaded Mem contents are intact.
